// File: rtl/bus_response_router_pkg.sv
// bus_response_router_pkg: shared bus types and constants for the CPU return path.
package bus_response_router_pkg;
    localparam int N_DEV = 8;
    localparam int DW    = 32;
    localparam int IW    = $clog2(N_DEV);
    localparam int DEV_BOOT   = 0;
    localparam int DEV_SDRAM  = 1;
    localparam int DEV_GPU    = 2;
    localparam int DEV_PS2    = 3;
    localparam int DEV_GPIO   = 4;
    localparam int DEV_HEX    = 5;
    localparam int DEV_TEST   = 6;
    localparam int DEV_SDCARD = 7;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/bus_response_router_if.sv
// bus_response_router_if: CPU request/completion and per-device strobe/ack bundle.
interface bus_response_router_if;
    import bus_response_router_pkg::*;
    logic                  i_req;
    logic [DW-1:0]         i_address;
    logic                  i_we;
    logic [DW-1:0]         i_wdata;
    logic [3:0]            i_byte_en;
    logic [N_DEV-1:0]      i_sel;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic [DW-1:0]         o_rdata;
    logic [N_DEV-1:0]      o_dev_req;
    logic [DW-1:0]         o_dev_address;
    logic [DW-1:0]         o_dev_wdata;
    logic                  o_dev_we;
    logic [3:0]            o_dev_byte_en;
    logic [N_DEV-1:0]      i_dev_ack;
    logic [N_DEV*DW-1:0]   i_dev_rdata;
    modport slave (
        input  i_req, i_address, i_we, i_wdata, i_byte_en, i_sel, i_dev_ack, i_dev_rdata,
        output o_busy, o_done, o_err, o_rdata, o_dev_req, o_dev_address, o_dev_wdata,
               o_dev_we, o_dev_byte_en
    );
    modport master (
        output i_req, i_address, i_we, i_wdata, i_byte_en, i_sel, i_dev_ack, i_dev_rdata,
        input  o_busy, o_done, o_err, o_rdata, o_dev_req, o_dev_address, o_dev_wdata,
               o_dev_we, o_dev_byte_en
    );
endinterface

// File: rtl/bus_onehot_encode.sv
// bus_onehot_encode: one-hot to index, valid only when exactly one bit is set.
module bus_onehot_encode
    import bus_response_router_pkg::*;
#(
    parameter int N = N_DEV
) (
    input  logic [N-1:0]         i_onehot,
    output logic [$clog2(N)-1:0] o_index,
    output logic                 o_valid
);
    always_comb begin
        o_index = '0;
        for (int k = 0; k < N; k++) o_index = i_onehot[k] ? o_index | ($clog2(N))'(k) : o_index;
        o_valid = $countones(i_onehot) == 1;
    end
endmodule

// File: rtl/bus_response_router.sv
// bus_response_router: strobes the decoder-selected device, waits for its ack, returns a one-cycle completion.
// Define BUS_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES with a bus-error completion.
module bus_response_router
    import bus_response_router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    bus_response_router_if.slave  bus
);
    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx;
    logic            w_valid;
    logic            w_ack;
    logic            w_expired;
    logic [DW-1:0]   w_slot;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    bus_onehot_encode #(.N(N_DEV)) u_sel_enc (
        .i_onehot (bus.i_sel),
        .o_index  (w_idx),
        .o_valid  (w_valid)
    );

    assign w_ack  = bus.i_dev_ack[r_idx];
    assign w_slot = bus.i_dev_rdata[DW*int'(r_idx) +: DW];

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    // Counts WAIT cycles; expiry on the last allowed cycle so RESP lands at 2+TIMEOUT_CYCLES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;
    end
    assign w_expired = r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= ST_IDLE;
            r_idx             <= '0;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_err         <= 1'b0;
            bus.o_rdata       <= '0;
            bus.o_dev_req     <= '0;
            bus.o_dev_address <= '0;
            bus.o_dev_wdata   <= '0;
            bus.o_dev_we      <= 1'b0;
            bus.o_dev_byte_en <= '0;
        end else begin
            bus.o_dev_req <= '0;
            bus.o_done    <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.i_req) begin
                    bus.o_dev_address <= bus.i_address;
                    bus.o_dev_wdata   <= bus.i_wdata;
                    bus.o_dev_we      <= bus.i_we;
                    bus.o_dev_byte_en <= bus.i_byte_en;
                    r_idx             <= w_idx;
                    bus.o_busy        <= 1'b1;
                    if (w_valid) begin
                        r_state       <= ST_ISSUE;
                        bus.o_dev_req <= bus.i_sel;
                    end else begin
                        r_state     <= ST_RESP;
                        bus.o_done  <= 1'b1;
                        bus.o_err   <= 1'b1;
                        bus.o_rdata <= '0;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: if (w_ack || w_expired) begin
                    r_state     <= ST_RESP;
                    bus.o_done  <= 1'b1;
                    bus.o_err   <= !w_ack;
                    bus.o_rdata <= (w_ack && !bus.o_dev_we) ? w_slot : '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/bus_response_router.md
# bus_response_router

Return-path half of the CPU system bus. It takes one CPU request plus the one-hot device-select vector produced by the address decoder and forwards the request as a single-cycle strobe to the selected peripheral. It then waits for that peripheral's acknowledge and hands read data or an error back to the CPU as a one-cycle completion. It sits between the CPU memory stage and the peripherals (bootloader ROM, SDRAM, GPU, PS/2, GPIO, HEX, test, SD card).

## Interface
- N_DEV, 8: number of peripheral slots; select/ack index order is bootloader=0, sdram=1, gpu=2, ps2=3, gpio=4, hex=5, test=6, sd_card=7.
- TIMEOUT_CYCLES, 1024: WAIT cycles allowed before bus-error completion; minimum 2.
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  CPU request strobe; sampled only while o_busy=0.
- i_address  in  32  request address; forwarded unchanged.
- i_we  in  1  1=write, 0=read.
- i_wdata  in  32  write data.
- i_byte_en  in  4  byte lanes.
- i_sel  in  N_DEV  decoder select vector for i_address; valid in the i_req cycle.
- o_busy  out  1  transaction in flight; high from the cycle after acceptance through the o_done cycle.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  qualified by o_done; 1=unmapped, multi-select or timeout.
- o_rdata  out  32  qualified by o_done; read data, 0 on writes and errors.
- o_dev_req  out  N_DEV  one-hot, one-cycle strobe to the selected device.
- o_dev_address, o_dev_wdata  out  32 each  latched request fields, stable from ISSUE through RESP.
- o_dev_we  out  1  latched i_we.
- o_dev_byte_en  out  4  latched i_byte_en.
- i_dev_ack  in  N_DEV  per-device acknowledge pulse.
- i_dev_rdata  in  N_DEV*32  per-device read data; slot k occupies bits [32k+31:32k]; valid with that device's ack.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, i_req=1:
  - Latch address, we, wdata, byte_en, and the device index.
  - popcount(i_sel)==1 → ISSUE.
  - popcount 0 (unmapped) or >1 (decoder fault) → RESP with error.
- ISSUE: o_dev_req[idx]=1 for exactly this cycle → WAIT; clear the timeout counter.
- WAIT:
  - i_dev_ack[idx]=1 → capture i_dev_rdata slot idx (0 if write) → RESP, err=0.
  - Acks from other devices are ignored.
  - Counter reaches TIMEOUT_CYCLES → RESP, err=1, rdata=0.
  - Ack in the same cycle as expiry: ack wins.
- RESP: o_done=1 for one cycle, o_err/o_rdata valid → IDLE.
- i_req while o_busy=1 is ignored. Acks received in IDLE/ISSUE/RESP are ignored, including late acks after a timeout.
- Reset, including mid-transaction: state=IDLE; o_busy, o_done, o_err, o_dev_req=0; o_rdata and latched fields=0. No completion is produced for the aborted transaction.

## Timing
- Cycle 0: i_req accepted.
- Cycle 1: ISSUE, o_dev_req pulse, o_busy=1.
- Earliest ack is cycle 2, giving o_done at cycle 3. Devices must not ack in the o_dev_req cycle.
- Read/write latency = 2 + ack delay in cycles.
- Unmapped/multi-select: o_done with o_err=1 at cycle 1; no o_dev_req.
- Timeout: o_done at cycle 2+TIMEOUT_CYCLES.
- Back-to-back: next i_req may be accepted in the cycle after o_done.
- All outputs are registered.

## Configuration
- BUS_TIMEOUT_EN defined: timeout counter present; behaviour as above.
- BUS_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely until the selected device acks. TIMEOUT_CYCLES is unused. Unmapped and multi-select errors are still reported.

## Structure
- Shared bus package holds: the state enum; device index constants (DEV_BOOT … DEV_SDCARD); N_DEV; the 32-bit data/address width constant.
- Sub-module bus_onehot_encode: N_DEV one-hot to index, plus a valid flag (exactly one bit set). Used for i_sel.
- Timeout counter stays inline, wrapped in the BUS_TIMEOUT_EN guard.

## Test plan
- Read GPIO: i_sel=8'h10, address 32'h4000_0000; device 4 acks at cycle 2 with slot-4 rdata=32'hCAFE_0001 → o_dev_req=8'h10 at cycle 1; o_done at cycle 3, o_rdata=32'hCAFE_0001, o_err=0.
- Write SDRAM: i_sel=8'h02, we=1, wdata=32'h1234_5678, byte_en=4'h3; ack after 5 cycles → o_dev_wdata/o_dev_byte_en stable until done; o_rdata=0; o_done at cycle 7.
- Unmapped and multi-select: i_sel=0 and i_sel=8'h06 → o_done with o_err=1 at cycle 1; o_dev_req never asserted.
- Foreign ack and timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): select PS/2, only device 2 acks → device 2 ack ignored; o_done with err=1 at cycle 6. A later ack from device 3 produces no second o_done.
- Ack on expiry cycle: ack on the last WAIT cycle → o_err=0, data returned.
- Reset during WAIT: deassert i_rst_n → all outputs 0 immediately. After release, a fresh request completes normally.
